carus_clk_gate_ctrl: RTL

//  Generates the enable for the carus clock-gating cell, running on the free-running clock on the ungated side.

---
 rtl/carus_clk_gate_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/carus_clk_gate_ctrl.sv
// Clock-enable controller for the carus clock-gating cell, clocked on the free-running side.
// Gates carus on idle timeout or software sleep, wakes on activity and stalls requests until the clock settles.
module carus_clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              auto_en_i,
    input  logic              force_on_i,
    input  logic              sleep_req_i,
    input  logic              wake_i,
    input  logic              busy_i,
    input  logic              req_i,
    output logic              req_stall_o,
    output logic              clk_en_o,
    output logic              gated_o,
    output logic              sleep_ack_o,
    input  logic              clr_stat_i,
    output logic [STAT_W-1:0] gated_cycles_o
);

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("carus_clk_gate_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake
        $error("carus_clk_gate_ctrl: WAKE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   idle_cnt, idle_cnt_next;
    logic [WW-1:0]   wake_cnt, wake_cnt_next;
    logic            sleep_entry, sleep_entry_next;
    logic            idle;
    logic            wake_src;

    assign idle     = !busy_i && !req_i && !wake_i;
    assign wake_src = req_i || wake_i || force_on_i || busy_i;

    always_comb begin
        state_next       = state;
        idle_cnt_next    = idle_cnt;
        wake_cnt_next    = wake_cnt;
        sleep_entry_next = sleep_entry;
        case (state)
            RUN: begin
                if (force_on_i || !idle || !auto_en_i) begin
                    idle_cnt_next = '0;
                end else if (idle_cnt != IDLE_LAST) begin
                    idle_cnt_next = idle_cnt + IW'(1);
                end
                // Software sleep outranks the auto timer; force-on and activity outrank both.
                if (!force_on_i && idle && sleep_req_i) begin
                    state_next       = GATED;
                    sleep_entry_next = 1'b1;
                    idle_cnt_next    = '0;
                end else if (!force_on_i && idle && auto_en_i && idle_cnt == IDLE_LAST) begin
                    state_next       = GATED;
                    sleep_entry_next = 1'b0;
                    idle_cnt_next    = '0;
                end
            end
            GATED: begin
                // Only a sleep-entered gating period ends when the request drops.
                if (wake_src || (sleep_entry && !sleep_req_i)) begin
                    state_next    = WAKE;
                    wake_cnt_next = '0;
                end
            end
            WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_next = RUN;
                end else begin
                    wake_cnt_next = wake_cnt + WW'(1);
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= RUN;
            idle_cnt       <= '0;
            wake_cnt       <= '0;
            sleep_entry    <= 1'b0;
            clk_en_o       <= 1'b1;
            gated_cycles_o <= '0;
        end else begin
            state       <= state_next;
            idle_cnt    <= idle_cnt_next;
            wake_cnt    <= wake_cnt_next;
            sleep_entry <= sleep_entry_next;
            clk_en_o    <= (state_next != GATED);
            if (clr_stat_i) begin
                gated_cycles_o <= '0;
            end else if (state == GATED && gated_cycles_o != {STAT_W{1'b1}}) begin
                gated_cycles_o <= gated_cycles_o + STAT_W'(1);
            end
        end
    end

    assign gated_o     = (state == GATED);
    assign sleep_ack_o = gated_o && sleep_req_i;
    assign req_stall_o = req_i && (state != RUN);

endmodule
